// File: rtl/z80_rot_dec_pkg.sv
// Shared definitions for the Z80 multi-byte BCD rotate sequencer.
// Z80_ROT_DEC_UNDOC_FLAGS_EN selects whether F bits 5/3 follow the result or F input.
package z80_rot_dec_pkg;

    localparam int MAX_BYTES_DEF = 16;

    localparam int FLAG_C_NUM  = 0;
    localparam int FLAG_N_NUM  = 1;
    localparam int FLAG_PV_NUM = 2;
    localparam int FLAG_3_NUM  = 3;
    localparam int FLAG_H_NUM  = 4;
    localparam int FLAG_5_NUM  = 5;
    localparam int FLAG_Z_NUM  = 6;
    localparam int FLAG_S_NUM  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } rot_state_t;

    // Even parity: 1 when the number of set bits is even.
    function automatic logic parity8(input logic [7:0] v);
        return ~^v;
    endfunction

    function automatic logic [7:0] rot_flags(input logic [7:0] a,
                                             input logic [7:0] f);
        logic [7:0] r;
        r              = '0;
        r[FLAG_S_NUM]  = a[7];
        r[FLAG_Z_NUM]  = (a == 8'h00);
        r[FLAG_PV_NUM] = parity8(a);
        r[FLAG_H_NUM]  = 1'b0;
        r[FLAG_N_NUM]  = 1'b0;
        r[FLAG_C_NUM]  = f[FLAG_C_NUM];
`ifdef Z80_ROT_DEC_UNDOC_FLAGS_EN
        r[FLAG_5_NUM]  = a[5];
        r[FLAG_3_NUM]  = a[3];
`else
        r[FLAG_5_NUM]  = f[FLAG_5_NUM];
        r[FLAG_3_NUM]  = f[FLAG_3_NUM];
`endif
        return r;
    endfunction

endpackage

// File: rtl/z80_rot_dec_step.sv
// Combinational per-byte nibble rotate step (RLD/RRD style).
// Produces the byte to write back and the nibble carried to the next byte.
module z80_rot_dec_step
    import z80_rot_dec_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic [3:0] i_carry,
    input  logic       i_left,
    output logic [7:0] o_wdata,
    output logic [3:0] o_carry
);

    always_comb begin
        o_wdata = 8'h00;
        o_carry = 4'h0;
        if (i_left) begin
            o_wdata = {i_byte[3:0], i_carry};
            o_carry = i_byte[7:4];
        end else begin
            o_wdata = {i_carry, i_byte[7:4]};
            o_carry = i_byte[3:0];
        end
    end

endmodule

// File: rtl/z80_rot_dec_seq.sv
// Multi-byte BCD string rotate (RLD/RRD extended over count bytes through memory).
// Z80_ROT_DEC_UNDOC_FLAGS_EN: F bits 5/3 taken from the result instead of F input.
module z80_rot_dec_seq
    import z80_rot_dec_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             left,
    input  logic [CNT_W-1:0] count,
    input  logic [15:0]      base_addr,
    input  logic [7:0]       a_in,
    input  logic [7:0]       f_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       a_out,
    output logic [7:0]       f_out,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack
);

    rot_state_t       r_state;
    rot_state_t       w_next;

    logic             r_left;
    logic [15:0]      r_addr;
    logic [CNT_W-1:0] r_rem;
    logic [3:0]       r_a_hi;
    logic [3:0]       r_carry;
    logic [7:0]       r_f;
    logic [7:0]       r_wdata;
    logic [7:0]       r_a_out;
    logic [7:0]       r_f_out;

    logic [CNT_W-1:0] w_cnt;
    logic [15:0]      w_first_addr;
    logic             w_last;
    logic [7:0]       w_wdata;
    logic [3:0]       w_carry_nx;
    logic [7:0]       w_a_res;

    assign w_cnt = (count > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : count;
    assign w_first_addr = left ? (base_addr + 16'(w_cnt) - 16'd1) : base_addr;
    assign w_last  = (r_rem == CNT_W'(1));
    assign w_a_res = {r_a_hi, r_carry};

    z80_rot_dec_step u_step (
        .i_byte  (mem_rdata),
        .i_carry (r_carry),
        .i_left  (r_left),
        .o_wdata (w_wdata),
        .o_carry (w_carry_nx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_cnt == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (mem_ack) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy   = 1'b1;
                mem_wr = 1'b1;
                if (mem_ack) begin
                    w_next = w_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_left  <= 1'b0;
            r_addr  <= 16'h0000;
            r_rem   <= '0;
            r_a_hi  <= 4'h0;
            r_carry <= 4'h0;
            r_f     <= 8'h00;
            r_wdata <= 8'h00;
            r_a_out <= 8'h00;
            r_f_out <= 8'h00;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_left  <= left;
                        r_addr  <= w_first_addr;
                        r_rem   <= w_cnt;
                        r_a_hi  <= a_in[7:4];
                        r_carry <= a_in[3:0];
                        r_f     <= f_in;
                        if (w_cnt == '0) begin
                            r_a_out <= a_in;
                            r_f_out <= rot_flags(a_in, f_in);
                        end
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        r_wdata <= w_wdata;
                        r_carry <= w_carry_nx;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        r_rem <= r_rem - CNT_W'(1);
                        if (w_last) begin
                            r_a_out <= w_a_res;
                            r_f_out <= rot_flags(w_a_res, r_f);
                        end else begin
                            r_addr <= r_left ? (r_addr - 16'd1)
                                             : (r_addr + 16'd1);
                        end
                    end
                end
                ST_DONE: begin
                end
            endcase
        end
    end

    assign a_out     = r_a_out;
    assign f_out     = r_f_out;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_z80_rot_dec_seq.sv
// Randomised bench for z80_rot_dec_seq against a nibble-string reference model.
// Build with and without Z80_ROT_DEC_UNDOC_FLAGS_EN to cover both flag sources.
module tb_z80_rot_dec_seq;

    localparam int MAXB = 16;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          left;
    logic [CW-1:0] count;
    logic [15:0]   base_addr;
    logic [7:0]    a_in;
    logic [7:0]    f_in;
    logic          busy;
    logic          done;
    logic [7:0]    a_out;
    logic [7:0]    f_out;
    logic          mem_rd;
    logic          mem_wr;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ack;

    z80_rot_dec_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .left      (left),
        .count     (count),
        .base_addr (base_addr),
        .a_in      (a_in),
        .f_in      (f_in),
        .busy      (busy),
        .done      (done),
        .a_out     (a_out),
        .f_out     (f_out),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic [7:0] mem [0:65535];
    txn_t       expq[$];
    logic [7:0] exp_a;
    logic [7:0] exp_f;
    int         exp_lat;
    int         t_start;
    int         waits;
    int         wcnt;
    int         wlim;
    int         wait_mode;
    int         n_acc;
    int         last_lat;
    int         lat;
    bit         active;
    bit         chk_en;
    bit         spur_ack;
    bit         have_result;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_flags(input logic [7:0] a,
                                               input logic [7:0] f);
        logic [7:0] r;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(a[i]);
        r    = 8'h00;
        r[7] = a[7];
        r[6] = (a == 8'h00);
        r[2] = (ones % 2 == 0);
        r[0] = f[0];
`ifdef Z80_ROT_DEC_UNDOC_FLAGS_EN
        r[5] = a[5];
        r[3] = a[3];
`else
        r[5] = f[5];
        r[3] = f[3];
`endif
        return r;
    endfunction

    // The string is one long BCD number, MS nibble at base; rotating it
    // by one nibble through A's low digit gives every written byte at once.
    task automatic model_op(input bit l, input int cnt, input logic [15:0] b,
                            input logic [7:0] a, input logic [7:0] f);
        logic [3:0]  nib[$];
        logic [3:0]  outn;
        logic [15:0] ad;
        txn_t        t;
        int          n;
        int          k;
        n = (cnt > MAXB) ? MAXB : cnt;
        for (int i = 0; i < n; i++) begin
            ad = b + 16'(i);
            nib.push_back(mem[ad][7:4]);
            nib.push_back(mem[ad][3:0]);
        end
        if (n == 0) begin
            outn = a[3:0];
        end else if (l) begin
            outn = nib.pop_front();
            nib.push_back(a[3:0]);
        end else begin
            outn = nib.pop_back();
            nib.push_front(a[3:0]);
        end
        expq.delete();
        for (int j = 0; j < n; j++) begin
            k      = l ? (n - 1 - j) : j;
            t.addr = b + 16'(k);
            t.wr   = 1'b0;
            t.data = 8'h00;
            expq.push_back(t);
            t.wr   = 1'b1;
            t.data = {nib[2*k], nib[2*k+1]};
            expq.push_back(t);
        end
        exp_a   = {a[7:4], outn};
        exp_f   = model_flags(exp_a, f);
        exp_lat = 2 * n + 1;
    endtask

    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        if (chk_en) begin
            check("rd_wr_excl", 32'(mem_rd & mem_wr), 0);
            check("busy", 32'(busy), 32'(active));
            if (active) begin
                lat = cyc - t_start;
                check("done", 32'(done), 32'(lat == exp_lat + waits));
                if (done) begin
                    check("a_out", 32'(a_out), 32'(exp_a));
                    check("f_out", 32'(f_out), 32'(exp_f));
                    check("txn_left", 32'(expq.size()), 0);
                    last_lat    = lat;
                    active      = 1'b0;
                    have_result = 1'b1;
                end
            end else begin
                check("done_idle", 32'(done), 0);
                if (have_result) begin
                    check("a_hold", 32'(a_out), 32'(exp_a));
                    check("f_hold", 32'(f_out), 32'(exp_f));
                end
            end
        end
        if (mem_rd || mem_wr) begin
            if (chk_en) begin
                check("req_expected", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    check("req_kind", 32'(mem_wr), 32'(expq[0].wr));
                    check("req_addr", 32'(mem_addr), 32'(expq[0].addr));
                    if (mem_wr)
                        check("wdata", 32'(mem_wdata), 32'(expq[0].data));
                end
            end
            if (wcnt >= wlim) begin
                mem_ack = 1'b1;
                if (mem_rd) mem_rdata = mem[mem_addr];
                if (mem_wr) mem[mem_addr] = mem_wdata;
                wcnt = 0;
                wlim = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
                n_acc++;
                if (chk_en && expq.size() != 0) void'(expq.pop_front());
            end else begin
                wcnt++;
                waits++;
            end
        end else if (spur_ack && $urandom_range(0, 3) == 0) begin
            mem_ack = 1'b1;
        end
    end

    task automatic do_reset();
        chk_en = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        active      = 1'b0;
        have_result = 1'b0;
        expq.delete();
    endtask

    task automatic launch(input bit l, input int cnt, input logic [15:0] b,
                          input logic [7:0] a, input logic [7:0] f,
                          input int wm);
        @(posedge clk);
        #1;
        have_result = 1'b0;
        model_op(l, cnt, b, a, f);
        left      = l;
        count     = CW'(cnt);
        base_addr = b;
        a_in      = a;
        f_in      = f;
        wait_mode = wm;
        wcnt      = 0;
        wlim      = (wm < 0) ? int'($urandom_range(0, 2)) : wm;
        waits     = 0;
        n_acc     = 0;
        t_start   = cyc;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        active    = 1'b1;
        left      = 1'($urandom);
        count     = CW'($urandom);
        base_addr = 16'($urandom);
        a_in      = 8'($urandom);
        f_in      = 8'($urandom);
    endtask

    task automatic run_op(input bit l, input int cnt, input logic [15:0] b,
                          input logic [7:0] a, input logic [7:0] f,
                          input int wm, input bit spur_start);
        int guard;
        launch(l, cnt, b, a, f, wm);
        guard = 0;
        while (active && guard < 400) begin
            @(posedge clk);
            #1;
            start = spur_start && active && ($urandom_range(0, 5) == 0);
            if (start) count = CW'($urandom_range(0, 3));
            guard++;
        end
        start = 1'b0;
        if (active) begin
            total++;
            bad++;
            $display("FAIL timeout actual=busy required=done");
            do_reset();
            chk_en = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        reset = 1'b1; start = 1'b0; left = 1'b0; count = '0;
        base_addr = '0; a_in = '0; f_in = '0;
        chk_en = 1'b0; active = 1'b0; spur_ack = 1'b0; have_result = 1'b0;
        wait_mode = 0; wcnt = 0; wlim = 0; waits = 0; n_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        check("rst_rd",     32'(mem_rd), 0);
        check("rst_wr",     32'(mem_wr), 0);
        check("rst_a",      32'(a_out), 0);
        check("rst_f",      32'(f_out), 0);
        check("rst_addr",   32'(mem_addr), 0);
        check("rst_wdata",  32'(mem_wdata), 0);
        chk_en = 1'b1;

        mem[16'h4000] = 8'h34;
        run_op(1'b1, 1, 16'h4000, 8'h12, 8'h00, 0, 1'b0);
        check("d1_mem", 32'(mem[16'h4000]), 32'h42);
        check("d1_a", 32'(a_out), 32'h13);
        check("d1_szp", 32'({f_out[7], f_out[6], f_out[2]}), 0);
        check("d1_lat", 32'(last_lat), 3);

        mem[16'h4000] = 8'h34;
        run_op(1'b0, 1, 16'h4000, 8'h12, 8'h00, 0, 1'b0);
        check("d2_mem", 32'(mem[16'h4000]), 32'h23);
        check("d2_a", 32'(a_out), 32'h14);
        check("d2_p", 32'(f_out[2]), 1);

        mem[16'hFFFE] = 8'h12;
        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h56;
        run_op(1'b1, 3, 16'hFFFE, 8'h05, 8'h00, 0, 1'b0);
        check("d3_m0000", 32'(mem[16'h0000]), 32'h65);
        check("d3_mffff", 32'(mem[16'hFFFF]), 32'h45);
        check("d3_mfffe", 32'(mem[16'hFFFE]), 32'h23);
        check("d3_a", 32'(a_out), 32'h01);

        run_op(1'b1, 0, 16'h1234, 8'h00, 8'h01, 0, 1'b0);
        check("d4_a", 32'(a_out), 0);
        check("d4_f", 32'(f_out), 32'h45);
        check("d4_acc", 32'(n_acc), 0);
        check("d4_lat", 32'(last_lat), 1);

        run_op(1'b0, 2, 16'h2000, 8'h99, 8'h00, 1, 1'b0);
        check("d5_lat", 32'(last_lat), 9);

        mem[16'h5000] = 8'h8F;
        run_op(1'b1, 1, 16'h5000, 8'h20, 8'h00, 0, 1'b0);
        check("d6_a", 32'(a_out), 32'h28);
`ifdef Z80_ROT_DEC_UNDOC_FLAGS_EN
        check("d6_f", 32'(f_out), 32'h2C);
`else
        check("d6_f", 32'(f_out), 32'h04);
`endif

        run_op(1'b0, 4, 16'h3000, 8'h47, 8'hFF, -1, 1'b1);
        run_op(1'b1, 20, 16'hFFF8, 8'hA3, 8'h28, 0, 1'b1);

        launch(1'b1, 3, 16'h6000, 8'h11, 8'h00, 0);
        for (int g = 0; g < 20 && !mem_wr; g++) begin
            @(posedge clk);
            #1;
        end
        check("d7_in_write", 32'(mem_wr), 1);
        chk_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("d7_wr", 32'(mem_wr), 0);
        check("d7_rd", 32'(mem_rd), 0);
        check("d7_busy", 32'(busy), 0);
        check("d7_done", 32'(done), 0);
        check("d7_a", 32'(a_out), 0);
        check("d7_addr", 32'(mem_addr), 0);
        active = 1'b0;
        have_result = 1'b0;
        expq.delete();
        chk_en = 1'b1;

        spur_ack = 1'b1;
        for (int r = 0; r < 60; r++) begin
            int          c;
            logic [15:0] b;
            c = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
            b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                            : 16'($urandom);
            run_op(1'($urandom), c, b, 8'($urandom), 8'($urandom), -1,
                   1'($urandom));
        end
        spur_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
